normalization_scheduler: RTL and testbench
==========================================

Name: normalization_scheduler

Overview:
- Shares the single descriptor-normalization pipeline between NUM_REQ descriptor generators, one per octave/lane.
- Round-robin arbitrates requests and issues one raw descriptor per cycle into the pipeline.
- Carries each descriptor's keypoint tag and source id through an in-order tag FIFO, then re-attaches them to the normalized result.
- Throttles issue with a downstream credit counter, because the normalization pipeline cannot stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DESC_IN_BITS, 1024, raw descriptor width (128 bins x 8 bits).
- DESC_OUT_BITS, 1280, normalized descriptor width (128 x 10 bits).
- KP_BITS, 32, keypoint tag width (x, y, octave, scale packed by producer).
- TAG_DEPTH, 32, tag FIFO depth; power of 2; must be >= pipeline latency for full throughput.
- CREDITS, 8, downstream buffer entries available after reset.

Ports:
- iclk  in  1  clock.
- ireset  in  1  asynchronous active-low reset.
- ienable  in  1  1 = new grants allowed.
- ireq_valid  in  NUM_REQ  request valid per requester.
- ireq_descriptor  in  NUM_REQ*DESC_IN_BITS  raw descriptors; slice i belongs to requester i.
- ireq_keypoint  in  NUM_REQ*KP_BITS  keypoint tags; slice i belongs to requester i.
- ogrant  out  NUM_REQ  combinational one-hot accept strobe.
- onorm_dval  out  1  issue strobe to the normalization pipeline.
- onorm_descriptor  out  DESC_IN_BITS  descriptor issued to the pipeline.
- inorm_dval  in  1  result valid from the pipeline.
- inorm_descriptor  in  DESC_OUT_BITS  normalized result from the pipeline.
- icredit_return  in  1  downstream freed one entry.
- odval  out  1  tagged result valid.
- odescriptor  out  DESC_OUT_BITS  normalized descriptor.
- okeypoint  out  KP_BITS  tag matching odescriptor.
- osrc  out  $clog2(NUM_REQ)  source requester index.
- obusy  out  1  work in flight.
- oerr  out  2  sticky errors: [0] result arrived with tag FIFO empty; [1] credit overflow.

Behaviour:
- Reset, asynchronous, ireset=0: all outputs 0; credit_cnt=CREDITS; rr_ptr=0; tag FIFO empty; oerr cleared (only reset clears it). Reset mid-operation discards everything in flight.
- Issue condition: ienable & |ireq_valid & credit_cnt!=0 & tag_count<TAG_DEPTH.
- Arbitration: when the issue condition holds, ogrant is one-hot to the first valid requester searching from rr_ptr upward, wrapping at NUM_REQ. Otherwise ogrant=0.
- Requester rule: hold valid and data until granted. Grant completes the transfer that cycle.
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant it holds.
- Issue latency: 1 cycle. On the cycle after a grant, onorm_dval=1 and onorm_descriptor = the granted slice (registered). onorm_descriptor holds its last value when idle.
- Tag FIFO: in the grant cycle, push {granted index, ireq_keypoint slice}. Pop on inorm_dval. Results return in issue order, so no reordering.
- Output stage, 1-cycle registered: odval <= inorm_dval; odescriptor <= inorm_descriptor; {osrc, okeypoint} <= FIFO head.
- Pop with FIFO empty: set oerr[0]; emit osrc=0, okeypoint=0; still assert odval.
- Credits:
  - Issue only: credit_cnt - 1.
  - Return only: credit_cnt + 1.
  - Issue and return in the same cycle: unchanged.
  - Return while credit_cnt==CREDITS: ignored and sets oerr[1].
- Back-to-back issue: allowed every cycle while the issue condition holds.
- Simultaneous push and pop: tag_count is unchanged; push is allowed at TAG_DEPTH-1. Full is checked on the registered count only; a same-cycle pop does not relieve full.
- ienable deassert: no new grants; in-flight work completes normally.
- obusy = tag_count!=0 | onorm_dval | odval.

Decomposition:
- Shared package: DESC_IN_BITS, DESC_OUT_BITS, KP_BITS, and the tag record layout {src, keypoint}.
- Sub-module normalization_tag_fifo: synchronous FIFO with push, pop, count, full, empty.
- Round-robin arbiter stays inline; it is roughly 30 lines.

Test Plan:
1. Single request: reset; req0 valid with descriptor pattern D0 and keypoint 0x00120034 -> ogrant=0001 same cycle; onorm_dval next cycle carrying D0. Drive inorm_dval 20 cycles later -> one cycle later odval=1, osrc=0, okeypoint=0x00120034.
2. Fairness: all 4 requesters valid continuously, credits returned every cycle -> grant order 0,1,2,3,0,1,... with no gaps; each gets 25% over 400 cycles.
3. Credit throttle: CREDITS=8, no credit returns, 12 requests -> exactly 8 onorm_dval pulses, then ogrant=0. One icredit_return -> exactly one more grant.
4. Ordering: issue 20 tagged requests from mixed sources with the pipeline model at latency 20 -> every odval carries the matching osrc/okeypoint in issue order; tag_count peaks at 20, then drains to 0 and obusy falls.
5. Errors: inorm_dval with FIFO empty -> oerr=01 sticky, odval=1 with zero tag. icredit_return at credit_cnt=8 -> oerr=11, credit_cnt stays 8.
6. Reset mid-stream: ireset=0 while 10 results are in flight -> all outputs 0 immediately, credit_cnt=8, FIFO empty. After release, a fresh request behaves as in test 1.

Source files
------------

// File: rtl/normalization_scheduler_pkg.sv
// Shared widths and the tag record that travels alongside each descriptor
// through the normalization pipeline.
package normalization_scheduler_pkg;
   localparam int DESC_IN_BITS  = 1024;
   localparam int DESC_OUT_BITS = 1280;
   localparam int KP_BITS       = 32;
   localparam int SRC_BITS      = 3;   // wide enough for up to 8 requesters

   typedef struct packed {
      logic [SRC_BITS-1:0] src;
      logic [KP_BITS-1:0]  keypoint;
   } tag_t;
endpackage

// File: rtl/normalization_tag_fifo.sv
// In-order FIFO of tag records; head is readable combinationally so the
// output stage can register it in the same cycle as the pop.
module normalization_tag_fifo
   import normalization_scheduler_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                   iclk,
   input  logic                   ireset,
   input  logic                   ipush,
   input  tag_t                   ipush_tag,
   input  logic                   ipop,
   output tag_t                   ohead,
   output logic [$clog2(DEPTH):0] ocount,
   output logic                   ofull,
   output logic                   oempty
);
   localparam int AW = $clog2(DEPTH);

   tag_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign ofull   = (count_q == (AW+1)'(DEPTH));
   assign oempty  = (count_q == '0);
   assign ocount  = count_q;
   assign ohead   = mem_q[rd_ptr_q];
   assign push_ok = ipush & ~ofull;
   assign pop_ok  = ipop & ~oempty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge iclk) begin
      if (push_ok) mem_q[wr_ptr_q] <= ipush_tag;
   end
endmodule

// File: rtl/normalization_scheduler.sv
// Round-robin scheduler feeding the shared normalization pipeline, with
// credit throttling and in-order re-attachment of keypoint/source tags.
module normalization_scheduler
   import normalization_scheduler_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 32,
   parameter int CREDITS   = 8
) (
   input  logic                         iclk,
   input  logic                         ireset,
   input  logic                         ienable,
   input  logic [NUM_REQ-1:0]           ireq_valid,
   input  logic [NUM_REQ*DESC_IN_BITS-1:0] ireq_descriptor,
   input  logic [NUM_REQ*KP_BITS-1:0]   ireq_keypoint,
   output logic [NUM_REQ-1:0]           ogrant,
   output logic                         onorm_dval,
   output logic [DESC_IN_BITS-1:0]      onorm_descriptor,
   input  logic                         inorm_dval,
   input  logic [DESC_OUT_BITS-1:0]     inorm_descriptor,
   input  logic                         icredit_return,
   output logic                         odval,
   output logic [DESC_OUT_BITS-1:0]     odescriptor,
   output logic [KP_BITS-1:0]           okeypoint,
   output logic [$clog2(NUM_REQ)-1:0]   osrc,
   output logic                         obusy,
   output logic [1:0]                   oerr
);
   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(CREDITS+1);
   localparam int TCW   = $clog2(TAG_DEPTH)+1;

   logic [DESC_IN_BITS-1:0] desc_slice [NUM_REQ];
   logic [KP_BITS-1:0]      kp_slice   [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign desc_slice[gi] = ireq_descriptor[gi*DESC_IN_BITS +: DESC_IN_BITS];
         assign kp_slice[gi]   = ireq_keypoint[gi*KP_BITS +: KP_BITS];
      end
   endgenerate

   logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]         credit_cnt_q, credit_cnt_d;
   logic                     onorm_dval_q, onorm_dval_d;
   logic [DESC_IN_BITS-1:0]  onorm_descriptor_q, onorm_descriptor_d;
   logic                     odval_q, odval_d;
   logic [DESC_OUT_BITS-1:0] odescriptor_q, odescriptor_d;
   logic [KP_BITS-1:0]       okeypoint_q, okeypoint_d;
   logic [SRC_W-1:0]         osrc_q, osrc_d;
   logic [1:0]               oerr_q, oerr_d;

   logic             found;
   logic [SRC_W-1:0] grant_idx, cand;
   logic             issue, credit_ovf;
   tag_t             push_tag, head_tag;
   logic [TCW-1:0]   tag_count;
   logic             tag_full, tag_empty;

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && ireq_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign issue = ireset & ienable & found & (credit_cnt_q != '0) & ~tag_full;
   assign ogrant = issue ? (NUM_REQ'(1) << grant_idx) : '0;
   assign credit_ovf = icredit_return & ~issue & (credit_cnt_q == CNT_W'(CREDITS));

   always_comb begin
      push_tag          = '0;
      push_tag.src      = SRC_BITS'(grant_idx);
      push_tag.keypoint = kp_slice[grant_idx];
   end

   normalization_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .iclk      (iclk),
      .ireset    (ireset),
      .ipush     (issue),
      .ipush_tag (push_tag),
      .ipop      (inorm_dval),
      .ohead     (head_tag),
      .ocount    (tag_count),
      .ofull     (tag_full),
      .oempty    (tag_empty)
   );

   always_comb begin
      rr_ptr_d           = rr_ptr_q;
      credit_cnt_d       = credit_cnt_q;
      onorm_dval_d       = issue;
      onorm_descriptor_d = onorm_descriptor_q;
      odval_d            = inorm_dval;
      odescriptor_d      = odescriptor_q;
      okeypoint_d        = okeypoint_q;
      osrc_d             = osrc_q;
      oerr_d             = oerr_q | {credit_ovf, inorm_dval & tag_empty};
      if (issue) begin
         rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
         onorm_descriptor_d = desc_slice[grant_idx];
      end
      if (issue && !icredit_return)
         credit_cnt_d = credit_cnt_q - CNT_W'(1);
      else if (!issue && icredit_return && !credit_ovf)
         credit_cnt_d = credit_cnt_q + CNT_W'(1);
      // An orphan result is still forwarded, but with a zeroed tag.
      if (inorm_dval) begin
         odescriptor_d = inorm_descriptor;
         okeypoint_d   = tag_empty ? '0 : head_tag.keypoint;
         osrc_d        = tag_empty ? '0 : head_tag.src[SRC_W-1:0];
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         rr_ptr_q           <= '0;
         credit_cnt_q       <= CNT_W'(CREDITS);
         onorm_dval_q       <= 1'b0;
         onorm_descriptor_q <= '0;
         odval_q            <= 1'b0;
         odescriptor_q      <= '0;
         okeypoint_q        <= '0;
         osrc_q             <= '0;
         oerr_q             <= '0;
      end else begin
         rr_ptr_q           <= rr_ptr_d;
         credit_cnt_q       <= credit_cnt_d;
         onorm_dval_q       <= onorm_dval_d;
         onorm_descriptor_q <= onorm_descriptor_d;
         odval_q            <= odval_d;
         odescriptor_q      <= odescriptor_d;
         okeypoint_q        <= okeypoint_d;
         osrc_q             <= osrc_d;
         oerr_q             <= oerr_d;
      end
   end

   assign onorm_dval       = onorm_dval_q;
   assign onorm_descriptor = onorm_descriptor_q;
   assign odval            = odval_q;
   assign odescriptor      = odescriptor_q;
   assign okeypoint        = okeypoint_q;
   assign osrc             = osrc_q;
   assign oerr             = oerr_q;
   assign obusy            = (tag_count != '0) | onorm_dval_q | odval_q;
endmodule

// File: tb/tb_normalization_scheduler.sv
// Directed bench for normalization_scheduler with a latency-20 pipeline model.
module tb_normalization_scheduler;
   localparam int NR = 4;
   localparam int DI = 1024;
   localparam int DO = 1280;
   localparam int LAT = 20;

   logic            iclk = 1'b0;
   logic            ireset;
   logic            ienable;
   logic [NR-1:0]   ireq_valid;
   logic [NR*DI-1:0] ireq_descriptor;
   logic [NR*32-1:0] ireq_keypoint;
   logic [NR-1:0]   ogrant;
   logic            onorm_dval;
   logic [DI-1:0]   onorm_descriptor;
   logic            inorm_dval;
   logic [DO-1:0]   inorm_descriptor;
   logic            icredit_return;
   logic            odval;
   logic [DO-1:0]   odescriptor;
   logic [31:0]     okeypoint;
   logic [1:0]      osrc;
   logic            obusy;
   logic [1:0]      oerr;

   int checks = 0;
   int errors = 0;

   logic            model_en;
   logic            man_dval;
   logic [DO-1:0]   man_desc;
   logic [LAT-1:0]  pv;
   logic [31:0]     pm [LAT];

   always #5 iclk = ~iclk;

   normalization_scheduler dut (
      .iclk(iclk), .ireset(ireset), .ienable(ienable),
      .ireq_valid(ireq_valid), .ireq_descriptor(ireq_descriptor),
      .ireq_keypoint(ireq_keypoint), .ogrant(ogrant),
      .onorm_dval(onorm_dval), .onorm_descriptor(onorm_descriptor),
      .inorm_dval(inorm_dval), .inorm_descriptor(inorm_descriptor),
      .icredit_return(icredit_return), .odval(odval),
      .odescriptor(odescriptor), .okeypoint(okeypoint), .osrc(osrc),
      .obusy(obusy), .oerr(oerr)
   );

   // Fixed-latency pipeline model: result marker = low word of input ^ 5A5A0000.
   always @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         pv <= '0;
         for (int i = 0; i < LAT; i++) pm[i] <= '0;
      end else begin
         pv    <= {pv[LAT-2:0], onorm_dval};
         pm[0] <= onorm_descriptor[31:0];
         for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
      end
   end

   assign inorm_dval       = model_en ? pv[LAT-1] : man_dval;
   assign inorm_descriptor = model_en ? {{(DO-32){1'b0}}, pm[LAT-1] ^ 32'h5A5A_0000} : man_desc;

   function automatic logic [DI-1:0] mk_desc(input int t);
      logic [DI-1:0] d;
      for (int j = 0; j < 32; j++) d[j*32 +: 32] = 32'(t*256 + j);
      return d;
   endfunction

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic do_reset();
      ireset = 1'b0; ienable = 1'b1; ireq_valid = '0; ireq_descriptor = '0;
      ireq_keypoint = '0; icredit_return = 1'b0; model_en = 1'b0;
      man_dval = 1'b0; man_desc = '0;
      repeat (2) tick();
      ireset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ogrant, onorm_dval, odval, obusy, oerr} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got grant=%b nd=%b odval=%b busy=%b err=%b want all 0",
                  ogrant, onorm_dval, odval, obusy, oerr);
      end
      checks++;
      if (onorm_descriptor !== '0 || odescriptor !== '0 || okeypoint !== '0 || osrc !== '0) begin
         errors++;
         $display("FAIL reset_data: got kp=%h src=%0d want 0 (descriptors also must be 0)", okeypoint, osrc);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [DO-1:0] r;
      do_reset();
      ireq_valid = 4'b0001;
      ireq_descriptor[0 +: DI] = mk_desc(1);
      ireq_keypoint[0 +: 32] = 32'h0012_0034;
      #1;
      checks++;
      if (ogrant !== 4'b0001) begin
         errors++; $display("FAIL single_grant: got %b want 0001", ogrant);
      end
      tick();
      ireq_valid = '0;
      checks++;
      if (onorm_dval !== 1'b1 || onorm_descriptor !== mk_desc(1)) begin
         errors++; $display("FAIL single_issue: got dval=%b low=%h want 1 low=%h",
                            onorm_dval, onorm_descriptor[31:0], 32'h100);
      end
      tick();
      checks++;
      if (onorm_dval !== 1'b0 || obusy !== 1'b1) begin
         errors++; $display("FAIL single_idle: got dval=%b busy=%b want 0 1", onorm_dval, obusy);
      end
      repeat (18) tick();
      r = {256'h0, mk_desc(9)};
      man_dval = 1'b1; man_desc = r;
      tick();
      man_dval = 1'b0;
      checks++;
      if (odval !== 1'b1 || osrc !== 2'd0 || okeypoint !== 32'h0012_0034 || odescriptor !== r) begin
         errors++; $display("FAIL single_result: got odval=%b src=%0d kp=%h want 1 0 00120034",
                            odval, osrc, okeypoint);
      end
      tick();
      checks++;
      if (odval !== 1'b0 || obusy !== 1'b0 || oerr !== 2'b00) begin
         errors++; $display("FAIL single_drain: got odval=%b busy=%b err=%b want 0 0 00", odval, obusy, oerr);
      end
      $display("test_single done");
   endtask

   task automatic test_fairness();
      int cnt [NR];
      logic [NR-1:0] exp_g;
      do_reset();
      model_en = 1'b1;
      icredit_return = 1'b1;
      for (int i = 0; i < NR; i++) begin
         cnt[i] = 0;
         ireq_descriptor[i*DI +: DI] = mk_desc(i);
      end
      ireq_valid = 4'b1111;
      #1;
      for (int c = 0; c < 400; c++) begin
         exp_g = 4'b0001 << (c % 4);
         checks++;
         if (ogrant !== exp_g) begin
            errors++; $display("FAIL fair_grant c=%0d: got %b want %b", c, ogrant, exp_g);
         end
         for (int i = 0; i < NR; i++) if (ogrant[i]) cnt[i]++;
         tick();
      end
      ireq_valid = '0;
      icredit_return = 1'b0;
      for (int i = 0; i < NR; i++) begin
         checks++;
         if (cnt[i] != 100) begin
            errors++; $display("FAIL fair_share req%0d: got %0d want 100", i, cnt[i]);
         end
      end
      repeat (LAT + 4) tick();
      $display("test_fairness done");
   endtask

   task automatic test_throttle();
      int pulses;
      do_reset();
      ienable = 1'b0;
      ireq_valid = 4'b1111;
      #1;
      checks++;
      if (ogrant !== 4'b0000) begin
         errors++; $display("FAIL enable_off: got %b want 0000", ogrant);
      end
      ienable = 1'b1;
      ireq_valid = 4'b0001;
      #1;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (onorm_dval) pulses++;
      end
      checks++;
      if (pulses != 8) begin
         errors++; $display("FAIL throttle_count: got %0d want 8", pulses);
      end
      checks++;
      if (ogrant !== 4'b0000) begin
         errors++; $display("FAIL throttle_block: got %b want 0000", ogrant);
      end
      icredit_return = 1'b1;
      #1;
      checks++;
      if (ogrant !== 4'b0000) begin
         errors++; $display("FAIL throttle_ret_cycle: got %b want 0000", ogrant);
      end
      tick();
      icredit_return = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (onorm_dval) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL throttle_one_more: got %0d want 1", pulses);
      end
      ireq_valid = '0;
      $display("test_throttle done");
   endtask

   task automatic test_ordering();
      int q_src[$];
      logic [31:0] q_kp[$];
      logic [31:0] q_mk[$];
      int s, nres, peak;
      logic [DO-1:0] exp_d;
      do_reset();
      model_en = 1'b1;
      nres = 0;
      peak = 0;
      for (int c = 0; c < 70; c++) begin
         if (c < 20) begin
            s = (c*3 + c/5) % 4;
            ireq_valid = 4'b0001 << s;
            ireq_descriptor[s*DI +: DI] = mk_desc(c + 100);
            ireq_keypoint[s*32 +: 32] = 32'hA000_0000 | 32'(c);
            icredit_return = 1'b1;
            #1;
            checks++;
            if (ogrant !== (4'b0001 << s)) begin
               errors++; $display("FAIL order_grant c=%0d: got %b want %b", c, ogrant, 4'b0001 << s);
            end
            q_src.push_back(s);
            q_kp.push_back(32'hA000_0000 | 32'(c));
            q_mk.push_back(32'((c + 100) * 256));
         end else begin
            ireq_valid = '0;
            icredit_return = 1'b0;
         end
         tick();
         if (int'(dut.tag_count) > peak) peak = int'(dut.tag_count);
         if (odval) begin
            checks++;
            if (q_src.size() == 0) begin
               errors++; $display("FAIL order_extra: got unexpected odval, want none");
            end else begin
               exp_d = {{(DO-32){1'b0}}, q_mk[0] ^ 32'h5A5A_0000};
               if (osrc !== 2'(q_src[0]) || okeypoint !== q_kp[0] || odescriptor !== exp_d) begin
                  errors++; $display("FAIL order_result %0d: got src=%0d kp=%h low=%h want src=%0d kp=%h low=%h",
                                     nres, osrc, okeypoint, odescriptor[31:0], q_src[0], q_kp[0], exp_d[31:0]);
               end
               void'(q_src.pop_front()); void'(q_kp.pop_front()); void'(q_mk.pop_front());
            end
            nres++;
         end
      end
      checks++;
      if (nres != 20) begin
         errors++; $display("FAIL order_count: got %0d want 20", nres);
      end
      checks++;
      if (peak != 20) begin
         errors++; $display("FAIL order_peak: got %0d want 20", peak);
      end
      checks++;
      if (obusy !== 1'b0 || dut.tag_count !== '0) begin
         errors++; $display("FAIL order_drain: got busy=%b count=%0d want 0 0", obusy, dut.tag_count);
      end
      $display("test_ordering done");
   endtask

   task automatic test_errors();
      int pulses;
      do_reset();
      man_dval = 1'b1;
      man_desc = {256'h0, mk_desc(3)};
      tick();
      man_dval = 1'b0;
      checks++;
      if (odval !== 1'b1 || osrc !== 2'd0 || okeypoint !== 32'h0 || oerr !== 2'b01 ||
          odescriptor !== {256'h0, mk_desc(3)}) begin
         errors++; $display("FAIL err_empty_pop: got odval=%b src=%0d kp=%h err=%b want 1 0 0 01",
                            odval, osrc, okeypoint, oerr);
      end
      repeat (3) tick();
      checks++;
      if (oerr !== 2'b01 || odval !== 1'b0) begin
         errors++; $display("FAIL err_sticky0: got err=%b odval=%b want 01 0", oerr, odval);
      end
      icredit_return = 1'b1;
      tick();
      icredit_return = 1'b0;
      checks++;
      if (oerr !== 2'b11) begin
         errors++; $display("FAIL err_credit_ovf: got %b want 11", oerr);
      end
      ireq_valid = 4'b0100;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (onorm_dval) pulses++;
      end
      ireq_valid = '0;
      checks++;
      if (pulses != 8) begin
         errors++; $display("FAIL err_credit_hold: got %0d grants want 8", pulses);
      end
      checks++;
      if (oerr !== 2'b11) begin
         errors++; $display("FAIL err_sticky1: got %b want 11", oerr);
      end
      $display("test_errors done");
   endtask

   task automatic test_reset_midstream();
      int pulses;
      logic [DO-1:0] r;
      do_reset();
      model_en = 1'b1;
      icredit_return = 1'b1;
      ireq_valid = 4'b0001;
      ireq_descriptor[0 +: DI] = mk_desc(5);
      repeat (10) tick();
      ireq_valid = '0;
      icredit_return = 1'b0;
      repeat (5) tick();
      ireq_valid = 4'b0010;
      #2;
      ireset = 1'b0;
      #1;
      checks++;
      if ({ogrant, onorm_dval, odval, obusy, oerr, osrc} !== '0 || okeypoint !== '0 ||
          onorm_descriptor !== '0 || odescriptor !== '0) begin
         errors++; $display("FAIL midrst_outputs: got grant=%b nd=%b odval=%b busy=%b err=%b want all 0",
                            ogrant, onorm_dval, odval, obusy, oerr);
      end
      checks++;
      if (dut.tag_count !== '0) begin
         errors++; $display("FAIL midrst_fifo: got count=%0d want 0", dut.tag_count);
      end
      ireq_valid = '0;
      model_en = 1'b0;
      tick();
      ireset = 1'b1;
      tick();
      ireq_valid = 4'b0001;
      ireq_descriptor[0 +: DI] = mk_desc(1);
      ireq_keypoint[0 +: 32] = 32'h0012_0034;
      #1;
      checks++;
      if (ogrant !== 4'b0001) begin
         errors++; $display("FAIL midrst_grant: got %b want 0001", ogrant);
      end
      tick();
      ireq_valid = '0;
      checks++;
      if (onorm_dval !== 1'b1 || onorm_descriptor !== mk_desc(1)) begin
         errors++; $display("FAIL midrst_issue: got dval=%b low=%h want 1 00000100",
                            onorm_dval, onorm_descriptor[31:0]);
      end
      repeat (20) tick();
      r = {256'h0, mk_desc(11)};
      man_dval = 1'b1; man_desc = r;
      tick();
      man_dval = 1'b0;
      checks++;
      if (odval !== 1'b1 || osrc !== 2'd0 || okeypoint !== 32'h0012_0034 || odescriptor !== r || oerr !== 2'b00) begin
         errors++; $display("FAIL midrst_result: got odval=%b src=%0d kp=%h err=%b want 1 0 00120034 00",
                            odval, osrc, okeypoint, oerr);
      end
      ireq_valid = 4'b1000;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (onorm_dval) pulses++;
      end
      ireq_valid = '0;
      checks++;
      if (pulses != 7) begin
         errors++; $display("FAIL midrst_credits: got %0d grants want 7", pulses);
      end
      $display("test_reset_midstream done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_throttle();
      test_ordering();
      test_errors();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
